// File: rtl/ctrl_hazard_unit_pkg.sv
// Shared widths, stall/flush bus bit positions and FSM state type for the
// ID->EX hazard control unit.
package ctrl_hazard_unit_pkg;

    localparam int CU_BUS_WIDTH    = 4;
    localparam int CU_STALL        = 0;
    localparam int CU_FLUSH        = 1;
    localparam int REG_ADDR_WIDTH  = 5;
    localparam int INST_ADDR_WIDTH = 32;

    localparam logic [INST_ADDR_WIDTH-1:0] ZERO_WORD = '0;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctrl_state_e;

    // Packs the stall and flush bits onto the control bus; the remaining bits are always 0.
    function automatic logic [CU_BUS_WIDTH-1:0] cu_bus(input logic stall, input logic flush);
        logic [CU_BUS_WIDTH-1:0] bus;
        bus           = '0;
        bus[CU_STALL] = stall;
        bus[CU_FLUSH] = flush;
        return bus;
    endfunction

endpackage

// File: rtl/ctrl_hazard_unit_reg_scoreboard.sv
// Pending-write bitmap for long-latency producers (loads, MDU ops), with one
// set port, one clear port and two combinational lookup ports.
module reg_scoreboard
    import ctrl_hazard_unit_pkg::*;
#(
    parameter int SB_REGS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_set_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_set_addr,
    input  logic                      i_clr_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_clr_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd2_addr,
    output logic                      o_rd1_busy,
    output logic                      o_rd2_busy
);

    logic [SB_REGS-1:0] r_sb;
    logic [SB_REGS-1:0] w_sb_nxt;

    // Clear is applied first so that a same-cycle set of the same register wins.
    always_comb begin
        w_sb_nxt = r_sb;
        for (int i = 0; i < SB_REGS; i++) begin
            if (i_clr_en && (i_clr_addr == REG_ADDR_WIDTH'(i))) begin
                w_sb_nxt[i] = 1'b0;
            end
            if (i_set_en && (i_set_addr == REG_ADDR_WIDTH'(i))) begin
                w_sb_nxt[i] = 1'b1;
            end
        end
        w_sb_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_nxt;
        end
    end

    always_comb begin
        o_rd1_busy = 1'b0;
        o_rd2_busy = 1'b0;
        for (int i = 1; i < SB_REGS; i++) begin
            if (i_rd1_addr == REG_ADDR_WIDTH'(i)) begin
                o_rd1_busy = r_sb[i];
            end
            if (i_rd2_addr == REG_ADDR_WIDTH'(i)) begin
                o_rd2_busy = r_sb[i];
            end
        end
    end

endmodule

// File: rtl/ctrl_hazard_unit.sv
// Stall/flush control for the ID->EX register: RAW and MDU structural stalls,
// multi-cycle flush after a redirect, and a registered redirect strobe to IFU.
//
// state | meaning
// RUN   | normal issue; flush only while jump_req_i is high
// FLUSH | holding flush for the remaining cycles of the last redirect
module ctrl_hazard_unit
    import ctrl_hazard_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int SB_REGS      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       jump_req_i,
    input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                       id_rs1_re_i,
    input  logic                       id_rs2_re_i,
    input  logic [REG_ADDR_WIDTH-1:0]  id_reg1_raddr_i,
    input  logic [REG_ADDR_WIDTH-1:0]  id_reg2_raddr_i,
    input  logic                       id_is_mdu_i,
    input  logic                       issue_valid_i,
    input  logic                       issue_long_i,
    input  logic                       issue_reg_we_i,
    input  logic [REG_ADDR_WIDTH-1:0]  issue_waddr_i,
    input  logic                       mdu_busy_i,
    input  logic                       wb_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0]  wb_waddr_i,
    output logic [CU_BUS_WIDTH-1:0]    stall_flag_o,
    output logic                       jump_flag_o,
    output logic [INST_ADDR_WIDTH-1:0] jump_addr_o
);

    localparam int            CNT_W       = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    // The request cycle already flushes, so a single-cycle flush never needs the FLUSH state.
    localparam bit            USE_FLUSH_ST = (FLUSH_CYCLES > 1);

    ctrl_state_e             r_state;
    ctrl_state_e             w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CNT_W-1:0]        w_cnt_dec;

    logic                    w_flush;
    logic                    w_raw_hz;
    logic                    w_struct_hz;
    logic                    w_stall;
    logic                    w_sb_set;
    logic                    w_rd1_busy;
    logic                    w_rd2_busy;

    logic                       r_jump_flag;
    logic [INST_ADDR_WIDTH-1:0] r_jump_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The exit test uses the decremented count so FLUSH lasts FLUSH_CYCLES-1 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_dec   = r_cnt - CNT_W'(1);
        case (r_state)
            RUN: begin
                if (jump_req_i && USE_FLUSH_ST) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            FLUSH: begin
                if (jump_req_i) begin
                    w_cnt_nxt = CNT_LOAD;
                end else if (w_cnt_dec == '0) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_dec;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_flush     = jump_req_i | (r_state == FLUSH);
        w_raw_hz    = (id_rs1_re_i & w_rd1_busy) | (id_rs2_re_i & w_rd2_busy);
        w_struct_hz = id_is_mdu_i & mdu_busy_i;
        w_stall     = ~w_flush & (w_raw_hz | w_struct_hz);
        w_sb_set    = issue_valid_i & issue_long_i & issue_reg_we_i
                      & (issue_waddr_i != '0) & ~w_flush;
    end

    assign stall_flag_o = cu_bus(w_stall, w_flush);

    reg_scoreboard #(
        .SB_REGS (SB_REGS)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_sb_set),
        .i_set_addr (issue_waddr_i),
        .i_clr_en   (wb_valid_i),
        .i_clr_addr (wb_waddr_i),
        .i_rd1_addr (id_reg1_raddr_i),
        .i_rd2_addr (id_reg2_raddr_i),
        .o_rd1_busy (w_rd1_busy),
        .o_rd2_busy (w_rd2_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jump_flag <= 1'b0;
            r_jump_addr <= ZERO_WORD;
        end else begin
            r_jump_flag <= jump_req_i;
            if (jump_req_i) begin
                r_jump_addr <= jump_addr_i;
            end
        end
    end

    assign jump_flag_o = r_jump_flag;
    assign jump_addr_o = r_jump_addr;

endmodule

// File: tb/tb_ctrl_hazard_unit.sv
// Self-checking bench for ctrl_hazard_unit: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_ctrl_hazard_unit;
    import ctrl_hazard_unit_pkg::*;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        id_rs1_re_i, id_rs2_re_i;
    logic [4:0]  id_reg1_raddr_i, id_reg2_raddr_i;
    logic        id_is_mdu_i;
    logic        issue_valid_i, issue_long_i, issue_reg_we_i;
    logic [4:0]  issue_waddr_i;
    logic        mdu_busy_i;
    logic        wb_valid_i;
    logic [4:0]  wb_waddr_i;
    logic [CU_BUS_WIDTH-1:0] stall_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;

    always #10 clk = ~clk;

    ctrl_hazard_unit #(.FLUSH_CYCLES(FC), .SB_REGS(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .jump_req_i      (jump_req_i),
        .jump_addr_i     (jump_addr_i),
        .id_rs1_re_i     (id_rs1_re_i),
        .id_rs2_re_i     (id_rs2_re_i),
        .id_reg1_raddr_i (id_reg1_raddr_i),
        .id_reg2_raddr_i (id_reg2_raddr_i),
        .id_is_mdu_i     (id_is_mdu_i),
        .issue_valid_i   (issue_valid_i),
        .issue_long_i    (issue_long_i),
        .issue_reg_we_i  (issue_reg_we_i),
        .issue_waddr_i   (issue_waddr_i),
        .mdu_busy_i      (mdu_busy_i),
        .wb_valid_i      (wb_valid_i),
        .wb_waddr_i      (wb_waddr_i),
        .stall_flag_o    (stall_flag_o),
        .jump_flag_o     (jump_flag_o),
        .jump_addr_o     (jump_addr_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: set of registers with a pending long write, number of
    // flush cycles still owed after the current one, and last redirect seen.
    bit          m_pending[32];
    int          m_flush_left;
    bit          m_jf;
    logic [31:0] m_ja;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_pending[i]) m_pending[i] = 1'b0;
        m_flush_left = 0;
        m_jf = 1'b0;
        m_ja = 32'h0;
    endtask

    task automatic idle();
        jump_req_i = 0; jump_addr_i = 32'h0;
        id_rs1_re_i = 0; id_rs2_re_i = 0; id_reg1_raddr_i = 0; id_reg2_raddr_i = 0;
        id_is_mdu_i = 0; issue_valid_i = 0; issue_long_i = 0; issue_reg_we_i = 0;
        issue_waddr_i = 0; mdu_busy_i = 0; wb_valid_i = 0; wb_waddr_i = 0;
    endtask

    function automatic bit exp_flush();
        return jump_req_i || (m_flush_left > 0);
    endfunction

    function automatic bit exp_stall();
        bit raw;
        raw = (id_rs1_re_i && m_pending[id_reg1_raddr_i]) ||
              (id_rs2_re_i && m_pending[id_reg2_raddr_i]);
        return !exp_flush() && (raw || (id_is_mdu_i && mdu_busy_i));
    endfunction

    // Spot check of one bus bit against a hand-derived constant.
    task automatic peek(input string tag, input int idx, input logic exp);
        #1;
        chk(tag, 32'(stall_flag_o[idx]), 32'(exp));
    endtask

    // Compare all outputs against the model for the current inputs, advance
    // the model, then step one clock.
    task automatic cycle(input string tag);
        logic [CU_BUS_WIDTH-1:0] exp_bus;
        bit f;
        #2;
        f = exp_flush();
        exp_bus = '0;
        exp_bus[CU_FLUSH] = f;
        exp_bus[CU_STALL] = exp_stall();
        chk({tag, "/bus"}, 32'(stall_flag_o), 32'(exp_bus));
        chk({tag, "/jflag"}, 32'(jump_flag_o), 32'(m_jf));
        chk({tag, "/jaddr"}, jump_addr_o, m_ja);
        if (wb_valid_i) m_pending[wb_waddr_i] = 1'b0;
        if (issue_valid_i && issue_long_i && issue_reg_we_i && issue_waddr_i != 0 && !f)
            m_pending[issue_waddr_i] = 1'b1;
        if (jump_req_i) begin
            m_flush_left = FC - 1;
            m_ja = jump_addr_i;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end
        m_jf = jump_req_i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset/bus", 32'(stall_flag_o), 32'h0);
        chk("reset/jflag", 32'(jump_flag_o), 32'h0);
        chk("reset/jaddr", jump_addr_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle("idle");

        // Load-use on x5: stall until the cycle after writeback
        issue_valid_i = 1; issue_long_i = 1; issue_reg_we_i = 1; issue_waddr_i = 5;
        cycle("ld_issue");
        idle();
        id_rs1_re_i = 1; id_reg1_raddr_i = 5;
        peek("ldu_stall0", CU_STALL, 1'b1);
        cycle("ldu0");
        peek("ldu_stall1", CU_STALL, 1'b1);
        cycle("ldu1");
        wb_valid_i = 1; wb_waddr_i = 5;
        peek("ldu_wb_cycle", CU_STALL, 1'b1);
        cycle("ldu_wb");
        wb_valid_i = 0;
        peek("ldu_after_wb", CU_STALL, 1'b0);
        cycle("ldu_done");

        // Same-cycle clear and set of x7: set wins
        idle();
        wb_valid_i = 1; wb_waddr_i = 7;
        issue_valid_i = 1; issue_long_i = 1; issue_reg_we_i = 1; issue_waddr_i = 7;
        cycle("setclr");
        idle();
        id_rs2_re_i = 1; id_reg2_raddr_i = 7;
        peek("setclr_stall", CU_STALL, 1'b1);
        cycle("setclr_rd");
        idle();
        wb_valid_i = 1; wb_waddr_i = 7;
        cycle("x7_clear");

        // Single redirect
        idle();
        jump_req_i = 1; jump_addr_i = 32'h8000_0100;
        peek("rd_flush0", CU_FLUSH, 1'b1);
        cycle("rd0");
        idle();
        peek("rd_flush1", CU_FLUSH, 1'b1);
        chk("rd_jflag", 32'(jump_flag_o), 32'h1);
        chk("rd_jaddr", jump_addr_o, 32'h8000_0100);
        cycle("rd1");
        peek("rd_flush2", CU_FLUSH, 1'b0);
        chk("rd_jflag_off", 32'(jump_flag_o), 32'h0);
        chk("rd_jaddr_hold", jump_addr_o, 32'h8000_0100);
        cycle("rd2");

        // Back-to-back redirect in the last flush cycle
        jump_req_i = 1; jump_addr_i = 32'h100;
        cycle("bb0");
        jump_req_i = 1; jump_addr_i = 32'h200;
        peek("bb_flush1", CU_FLUSH, 1'b1);
        cycle("bb1");
        idle();
        peek("bb_flush2", CU_FLUSH, 1'b1);
        chk("bb_jaddr", jump_addr_o, 32'h200);
        cycle("bb2");
        peek("bb_flush3", CU_FLUSH, 1'b0);
        cycle("bb3");

        // Flush over stall priority, structural hazard, x0 handling
        issue_valid_i = 1; issue_long_i = 1; issue_reg_we_i = 1; issue_waddr_i = 9;
        cycle("x9_issue");
        idle();
        id_rs1_re_i = 1; id_reg1_raddr_i = 9; jump_req_i = 1; jump_addr_i = 32'h40;
        peek("prio_stall", CU_STALL, 1'b0);
        peek("prio_flush", CU_FLUSH, 1'b1);
        cycle("prio");
        idle();
        cycle("prio_tail");
        id_is_mdu_i = 1; mdu_busy_i = 1;
        peek("mdu_struct", CU_STALL, 1'b1);
        cycle("mdu");
        idle();
        issue_valid_i = 1; issue_long_i = 1; issue_reg_we_i = 1; issue_waddr_i = 0;
        cycle("x0_issue");
        idle();
        id_rs1_re_i = 1; id_rs2_re_i = 1;
        peek("x0_read", CU_STALL, 1'b0);
        cycle("x0_read");
        idle();
        wb_valid_i = 1; wb_waddr_i = 9;
        cycle("x9_clear");

        // Reset asserted while flushing
        idle();
        jump_req_i = 1; jump_addr_i = 32'h1234;
        cycle("rst_jump");
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_async_bus", 32'(stall_flag_o), 32'h0);
        chk("rst_async_jflag", 32'(jump_flag_o), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        peek("rst_run", CU_FLUSH, 1'b0);
        cycle("post_rst");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            jump_req_i      = ($urandom_range(0, 7) == 0);
            jump_addr_i     = $urandom;
            id_rs1_re_i     = $urandom_range(0, 1);
            id_rs2_re_i     = $urandom_range(0, 1);
            id_reg1_raddr_i = 5'($urandom_range(0, 7));
            id_reg2_raddr_i = 5'($urandom_range(0, 7));
            id_is_mdu_i     = $urandom_range(0, 1);
            mdu_busy_i      = ($urandom_range(0, 3) == 0);
            issue_valid_i   = $urandom_range(0, 1);
            issue_long_i    = $urandom_range(0, 1);
            issue_reg_we_i  = $urandom_range(0, 1);
            issue_waddr_i   = 5'($urandom_range(0, 7));
            wb_valid_i      = ($urandom_range(0, 2) == 0);
            wb_waddr_i      = 5'($urandom_range(0, 7));
            cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
